// File: rtl/pts_stream_sr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pts_pkg
//  Description : Shared types and default constants for the pts_stream_sr
//                parallel-to-serial transmit serializer.
//                  pts_state_t           - serializer FSM states
//                  PTS_DEFAULT_NUM_BITS  - default word width
//                  PTS_DEFAULT_IDLE_LEVEL- default idle line level / fill bit
//  Revision    : 1.0 - initial release
// ============================================================================
package pts_pkg;

    typedef enum logic {
        PTS_IDLE  = 1'b0,
        PTS_SHIFT = 1'b1
    } pts_state_t;

    localparam int   PTS_DEFAULT_NUM_BITS   = 8;
    localparam logic PTS_DEFAULT_IDLE_LEVEL = 1'b1;

endpackage : pts_pkg
`default_nettype wire

// File: rtl/pts_stream_sr_if.sv
`default_nettype none
// ============================================================================
//  Module      : pts_stream_sr_if
//  Description : Valid/ready word-load channel into the serializer.
//                  in_valid  producer -> serializer  word offered
//                  in_data   producer -> serializer  word to send
//                  in_ready  serializer -> producer  holding buffer empty
//                Modports: master (producer side), slave (serializer side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pts_stream_sr_if #(
    parameter int NUM_BITS = 8
);
    logic                in_valid;
    logic [NUM_BITS-1:0] in_data;
    logic                in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface : pts_stream_sr_if
`default_nettype wire

// File: rtl/pts_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pts_bit_counter
//  Description : Rollover bit counter 0 .. NUM_BITS-1 for the serializer.
//                  clk          in  system clock
//                  n_rst        in  synchronous active-low reset
//                  clear        in  synchronous return to 0 (beats enable)
//                  count_enable in  advance by one, wrapping to 0 after last
//                  last         out count == NUM_BITS-1
//  Revision    : 1.0 - initial release
// ============================================================================
module pts_bit_counter #(
    parameter int NUM_BITS = 8
) (
    input  wire logic clk,
    input  wire logic n_rst,
    input  wire logic clear,
    input  wire logic count_enable,
    output logic      last
);
    localparam int CNT_W = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_BITS - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            r_count <= (r_count == C_LAST) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign last = (r_count == C_LAST);

endmodule : pts_bit_counter
`default_nettype wire

// File: rtl/pts_stream_sr.sv
`default_nettype none
// ============================================================================
//  Module      : pts_stream_sr
//  Description : Parametrised parallel-to-serial transmit serializer with a
//                one-word holding buffer. Words stream back-to-back; bits
//                advance on the external bit-period strobe.
//                  clk        in  system clock
//                  n_rst      in  synchronous active-low reset
//                  clear      in  synchronous abort of word in flight + held
//                  strobe     in  bit-period tick, ends the current bit
//                  bus        slave valid/ready word-load channel
//                  serial_out out current line bit
//                  busy       out word in flight
//                  word_done  out one-cycle pulse after a word's last bit
//  Revision    : 1.0 - initial release
// ============================================================================
module pts_stream_sr
    import pts_pkg::*;
#(
    parameter int   NUM_BITS   = PTS_DEFAULT_NUM_BITS,
    parameter bit   SHIFT_MSB  = 1'b0,
    parameter logic IDLE_LEVEL = PTS_DEFAULT_IDLE_LEVEL
) (
    input  wire logic        clk,
    input  wire logic        n_rst,
    input  wire logic        clear,
    input  wire logic        strobe,
    pts_stream_sr_if.slave   bus,
    output logic             serial_out,
    output logic             busy,
    output logic             word_done
);

    pts_state_t          r_state;
    pts_state_t          w_state_next;
    logic [NUM_BITS-1:0] r_sr;
    logic [NUM_BITS-1:0] r_hold;
    logic                r_hold_full;
    logic                r_word_done;

    logic                w_last;
    logic                w_final;
    logic                w_slot;
    logic                w_load_hold;
    logic                w_load_direct;
    logic                w_load;
    logic                w_accept;
    logic                w_shift;
    logic [NUM_BITS-1:0] w_load_word;
    logic [NUM_BITS-1:0] w_sr_shifted;
    logic                w_line_bit;

    // The final strobe of a word opens the same load slot as being idle,
    // which is what lets the next word start on that edge with no gap.
    assign w_final       = (r_state == PTS_SHIFT) && strobe && w_last;
    assign w_slot        = (r_state == PTS_IDLE) || w_final;
    assign w_load_hold   = w_slot && r_hold_full;
    assign w_load_direct = w_slot && !r_hold_full && bus.in_valid;
    assign w_load        = w_load_hold || w_load_direct;
    assign w_accept      = bus.in_valid && !r_hold_full;
    assign w_shift       = (r_state == PTS_SHIFT) && strobe && !w_last;
    assign w_load_word   = r_hold_full ? r_hold : bus.in_data;

    generate
        if (SHIFT_MSB) begin : g_msb_first
            assign w_sr_shifted = {r_sr[NUM_BITS-2:0], IDLE_LEVEL};
            assign w_line_bit   = r_sr[NUM_BITS-1];
        end else begin : g_lsb_first
            assign w_sr_shifted = {IDLE_LEVEL, r_sr[NUM_BITS-1:1]};
            assign w_line_bit   = r_sr[0];
        end
    endgenerate

    // Counter restarts on every load (and clear); a final strobe without a
    // following load wraps it to 0, matching the idle value.
    pts_bit_counter #(
        .NUM_BITS(NUM_BITS)
    ) u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear || w_load),
        .count_enable ((r_state == PTS_SHIFT) && strobe),
        .last         (w_last)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= PTS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = PTS_IDLE;
        end else if (w_load) begin
            w_state_next = PTS_SHIFT;
        end else if (w_final) begin
            w_state_next = PTS_IDLE;
        end
    end

    // ---------------- shift register ----------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sr <= {NUM_BITS{IDLE_LEVEL}};
        end else if (!clear) begin
            if (w_load) begin
                r_sr <= w_load_word;
            end else if (w_shift) begin
                r_sr <= w_sr_shifted;
            end
        end
    end

    // ---------------- holding buffer ----------------
    // A word accepted in a load slot goes straight into sr; only words
    // accepted while shifting are parked here.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (clear) begin
            r_hold_full <= 1'b0;
        end else if (w_load_hold) begin
            r_hold_full <= 1'b0;
        end else if (w_accept && !w_load_direct) begin
            r_hold      <= bus.in_data;
            r_hold_full <= 1'b1;
        end
    end

    // ---------------- word_done ----------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_word_done <= 1'b0;
        end else if (clear) begin
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= w_final;
        end
    end

    assign busy         = (r_state == PTS_SHIFT);
    assign serial_out   = busy ? w_line_bit : IDLE_LEVEL;
    assign word_done    = r_word_done;
    assign bus.in_ready = !r_hold_full;

endmodule : pts_stream_sr
`default_nettype wire

// File: tb/tb_pts_stream_sr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pts_stream_sr
//  Description : Self-checking bench for pts_stream_sr. Drives an LSB-first
//                and an MSB-first instance with identical stimulus and
//                compares both against a word/bit-index reference model,
//                plus directed checks of captured line words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pts_stream_sr;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         clear;
    logic         strobe;
    logic         in_valid;
    logic [N-1:0] in_data;

    logic serial_l, busy_l, done_l;
    logic serial_m, busy_m, done_m;

    int total = 0;
    int bad   = 0;
    int ndone = 0;

    // reference model state: word in flight + bit index, one-slot buffer
    bit         m_busy;
    bit [N-1:0] m_word;
    int         m_idx;
    bit         m_hold_full;
    bit [N-1:0] m_hold;
    bit         m_done;

    always #5 clk = ~clk;

    pts_stream_sr_if #(.NUM_BITS(N)) bus_l ();
    pts_stream_sr_if #(.NUM_BITS(N)) bus_m ();

    assign bus_l.in_valid = in_valid;
    assign bus_l.in_data  = in_data;
    assign bus_m.in_valid = in_valid;
    assign bus_m.in_data  = in_data;

    pts_stream_sr #(.NUM_BITS(N), .SHIFT_MSB(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .strobe     (strobe),
        .bus        (bus_l),
        .serial_out (serial_l),
        .busy       (busy_l),
        .word_done  (done_l)
    );

    pts_stream_sr #(.NUM_BITS(N), .SHIFT_MSB(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .strobe     (strobe),
        .bus        (bus_m),
        .serial_out (serial_m),
        .busy       (busy_m),
        .word_done  (done_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, from the rules for words.
    task automatic model_edge();
        bit ready, fin, slot;
        if (!n_rst) begin
            m_busy = 0; m_idx = 0; m_hold_full = 0; m_hold = '0; m_done = 0;
        end else if (clear) begin
            m_busy = 0; m_idx = 0; m_hold_full = 0; m_done = 0;
        end else begin
            ready  = !m_hold_full;
            fin    = m_busy && strobe && (m_idx == N - 1);
            slot   = !m_busy || fin;
            m_done = fin;
            if (m_busy && strobe && !fin) m_idx++;
            if (slot) begin
                if (m_hold_full) begin
                    m_word = m_hold; m_hold_full = 0; m_busy = 1; m_idx = 0;
                end else if (in_valid) begin
                    m_word = in_data; m_busy = 1; m_idx = 0;
                end else begin
                    m_busy = 0; m_idx = 0;
                end
            end else if (in_valid && ready) begin
                m_hold = in_data; m_hold_full = 1;
            end
        end
    endtask

    task automatic check_all();
        logic exp_l, exp_m;
        exp_l = m_busy ? m_word[m_idx] : 1'b1;
        exp_m = m_busy ? m_word[N-1-m_idx] : 1'b1;
        chk("serial_lsb", serial_l, exp_l);
        chk("serial_msb", serial_m, exp_m);
        chk("busy_lsb", busy_l, m_busy);
        chk("busy_msb", busy_m, m_busy);
        chk("ready_lsb", bus_l.in_ready, !m_hold_full);
        chk("ready_msb", bus_m.in_ready, !m_hold_full);
        chk("done_lsb", done_l, m_done);
        chk("done_msb", done_m, m_done);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (done_l === 1'b1) ndone++;
    endtask

    // Sample the current word bit-by-bit, strobing every 'gap' cycles.
    task automatic shift_capture(input int gap, output logic [N-1:0] cap_l,
                                 output logic [N-1:0] cap_m);
        for (int k = 0; k < N; k++) begin
            cap_l[k]     = serial_l;
            cap_m[N-1-k] = serial_m;
            repeat (gap - 1) step();
            strobe = 1'b1;
            step();
            strobe = 1'b0;
        end
    endtask

    task automatic send_word(input logic [N-1:0] d, input int gap,
                             output logic [N-1:0] cap_l, output logic [N-1:0] cap_m);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        shift_capture(gap, cap_l, cap_m);
    endtask

    initial begin : main
        logic [N-1:0] cl, cm;
        int d0;

        n_rst = 1'b0; clear = 1'b0; strobe = 1'b0; in_valid = 1'b0; in_data = '0;
        step();
        step();
        chk("rst_line", serial_l, 1'b1);
        chk("rst_ready", bus_l.in_ready, 1'b1);
        chk("rst_busy", busy_l, 1'b0);
        n_rst = 1'b1;
        step();

        // LSB and MSB: 0xA5, strobe every 4 cycles
        d0 = ndone;
        send_word(8'hA5, 4, cl, cm);
        chk("a5_lsb_word", cl, 8'hA5);
        chk("a5_msb_word", cm, 8'hA5);
        chk("a5_done_pulse", done_l, 1'b1);
        chk("a5_line_idle", serial_l, 1'b1);
        step();
        chk("a5_done_one_cycle", done_l, 1'b0);
        chk("a5_done_count", ndone - d0, 1);

        // 0x0F
        send_word(8'h0F, 3, cl, cm);
        chk("0f_lsb_word", cl, 8'h0F);
        chk("0f_msb_word", cm, 8'h0F);
        repeat (3) step();

        // back-to-back 0x3C then 0xC3
        d0 = ndone;
        in_valid = 1'b1; in_data = 8'h3C;
        step();
        in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        chk("b2b_ready_low", bus_l.in_ready, 1'b0);
        shift_capture(2, cl, cm);
        chk("b2b_w0", cl, 8'h3C);
        chk("b2b_nogap_busy", busy_l, 1'b1);
        chk("b2b_ready_high", bus_l.in_ready, 1'b1);
        shift_capture(2, cl, cm);
        chk("b2b_w1", cl, 8'hC3);
        chk("b2b_w1_msb", cm, 8'hC3);
        chk("b2b_done_count", ndone - d0, 2);
        repeat (2) step();

        // final-strobe bypass: 0x81 offered on the last strobe of 0x12
        in_valid = 1'b1; in_data = 8'h12;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            step();
            strobe = 1'b1;
            if (k == N - 1) begin
                in_valid = 1'b1;
                in_data  = 8'h81;
            end
            step();
            strobe = 1'b0;
            in_valid = 1'b0;
        end
        chk("bypass_busy", busy_l, 1'b1);
        chk("bypass_ready", bus_l.in_ready, 1'b1);
        shift_capture(2, cl, cm);
        chk("bypass_word", cl, 8'h81);
        repeat (2) step();

        // clear after 3 bits of 0xFF with 0x55 held
        in_valid = 1'b1; in_data = 8'hFF;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            strobe = 1'b1;
            step();
            strobe = 1'b0;
        end
        in_valid = 1'b1; in_data = 8'h55;
        step();
        in_valid = 1'b0;
        chk("clr_hold_full", bus_l.in_ready, 1'b0);
        d0 = ndone;
        clear = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_line", serial_l, 1'b1);
        chk("clr_ready", bus_l.in_ready, 1'b1);
        chk("clr_busy", busy_l, 1'b0);
        for (int k = 0; k < 6; k++) begin
            strobe = k[0];
            step();
        end
        strobe = 1'b0;
        chk("clr_no_done", ndone - d0, 0);
        send_word(8'h01, 2, cl, cm);
        chk("clr_next_word", cl, 8'h01);
        step();

        // reset mid-word
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_data = 8'h66;
        step();
        in_valid = 1'b0;
        strobe = 1'b1; step(); step(); strobe = 1'b0;
        n_rst = 1'b0;
        step();
        chk("mrst_line", serial_l, 1'b1);
        chk("mrst_ready", bus_l.in_ready, 1'b1);
        chk("mrst_busy", busy_l, 1'b0);
        chk("mrst_done", done_l, 1'b0);
        n_rst = 1'b1;
        d0 = ndone;
        for (int k = 0; k < 8; k++) begin
            strobe = k[0];
            step();
        end
        strobe = 1'b0;
        chk("idle_strobe_busy", busy_l, 1'b0);
        chk("idle_strobe_done", ndone - d0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            n_rst    = ($urandom_range(0, 299) != 0);
            clear    = ($urandom_range(0, 149) == 0);
            strobe   = ($urandom_range(0, 2) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = N'($urandom);
            step();
        end
        n_rst = 1'b1; clear = 1'b0; strobe = 1'b0; in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pts_stream_sr
`default_nettype wire
